// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit "+"/"*" expressions with operator precedence.
// Sums of closed products live in acc; the running product lives in term.
module expr_eval (
   input  logic        clk,
   input  logic        clr,
   input  logic [7:0]  in,
   input  logic        in_valid,
   output logic [31:0] result,
   output logic        ok,
   output logic        err,
   output logic        busy
);

   typedef enum logic [1:0] {START, OPND, OPER, ERR} state_t;

   state_t      state, state_nx;
   logic [31:0] acc, acc_nx;
   logic [31:0] term, term_nx;
   logic [31:0] result_nx;
   logic [31:0] dval;
   logic        pmul, pmul_nx;
   logic        is_dig, is_add, is_mul;

   always_comb begin
      is_dig = (in >= 8'h30) && (in <= 8'h39);
      is_add = (in == 8'h2b);
      is_mul = (in == 8'h2a);
      dval   = {28'd0, in[3:0]};
   end

   always_comb begin
      state_nx  = state;
      acc_nx    = acc;
      term_nx   = term;
      pmul_nx   = pmul;
      result_nx = result;
      if (in_valid) begin
         case (state)
            START: begin
               if (is_dig) begin
                  acc_nx    = '0;
                  term_nx   = dval;
                  result_nx = dval;
                  state_nx  = OPND;
               end else begin
                  state_nx = ERR;
               end
            end
            OPND: begin
               if (is_add) begin
                  acc_nx   = acc + term;
                  pmul_nx  = 1'b0;
                  state_nx = OPER;
               end else if (is_mul) begin
                  pmul_nx  = 1'b1;
                  state_nx = OPER;
               end else begin
                  state_nx = ERR;
               end
            end
            OPER: begin
               if (is_dig) begin
                  term_nx   = pmul ? (term * dval) : dval;
                  // result reflects the updated term, not the registered one
                  result_nx = acc + term_nx;
                  state_nx  = OPND;
               end else begin
                  state_nx = ERR;
               end
            end
            default: state_nx = ERR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= START;
         acc    <= '0;
         term   <= '0;
         pmul   <= 1'b0;
         result <= '0;
         ok     <= 1'b0;
         err    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nx;
         acc    <= acc_nx;
         term   <= term_nx;
         pmul   <= pmul_nx;
         result <= result_nx;
         ok     <= (state_nx == OPND);
         err    <= (state_nx == ERR);
         if (in_valid)
            busy <= 1'b1;
      end
   end

endmodule
